prog_loader: RTL and testbench
==============================

# prog_loader

Program loader that fills the 256x8 instruction memory from a byte stream while the processor is held in reset. It receives framed bytes over a valid/ready handshake, issues one memory write per data byte and verifies an 8-bit checksum. On success it releases the processor; on failure it keeps the processor held and flags an error. It sits between the host/debug link and the instruction memory write port, and is the writer for the memory the fetch stage reads through PC.

## Interface

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1024, idle cycles allowed between bytes inside a frame (>= 2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction memory write enable, one-cycle pulse per data byte.
- mem_addr  out  8  write address.
- mem_wdata  out  8  write data.
- cpu_hold  out  1  holds the processor in reset while high.
- load_done  out  1  last frame verified OK (level).
- load_err  out  1  last frame failed on checksum or timeout (level).
- busy  out  1  frame in progress (state is not IDLE).

## Operation

- A byte is accepted on any rising edge where in_valid and in_ready are both high.
- in_ready is 1 in every state after reset. Back-to-back bytes are accepted at one per cycle.
- Frame format:
  - SYNC_BYTE
  - ADDR (start address)
  - LEN (data byte count; 0 means 256)
  - LEN data bytes
  - CSUM
- The frame is valid when (ADDR + LEN + sum of data + CSUM) mod 256 == 0.
- State machine:
  - IDLE: a byte equal to SYNC_BYTE moves to S_ADDR. It also clears load_done and load_err and sets cpu_hold. Any other byte is discarded with no state change.
  - S_ADDR: latch the write pointer := byte and sum := byte, then go to S_LEN.
  - S_LEN: latch remaining := byte (0 is treated as 256) and add the byte to sum, then go to S_DATA.
  - S_DATA: for each byte, write it to the pointer, increment the pointer mod 256, add the byte to sum and decrement remaining. When remaining reaches 0, go to S_CSUM.
  - S_CSUM: if (sum + byte) mod 256 == 0, set load_done=1 and cpu_hold=0. Otherwise set load_err=1 and keep cpu_hold=1. Return to IDLE in either case.
- SYNC_BYTE values inside a frame are ordinary payload. There is no mid-frame resync.
- Timeout:
  - An idle counter clears on every accepted byte and counts cycles in states other than IDLE.
  - When it reaches TIMEOUT with no byte accepted, set load_err=1, keep cpu_hold=1 and return to IDLE.
  - Data already written stays written.
- A simultaneous byte acceptance and timeout expiry counts as acceptance, so no timeout occurs.
- All sum and address arithmetic is 8-bit with silent wrap. The address 0xFF is followed by 0x00.

## Timing

- Reset values:
  - in_ready=0 while rst is high, 1 from the first edge after release.
  - mem_we=0, mem_addr=0x00, mem_wdata=0x00.
  - cpu_hold=1, load_done=0, load_err=0, busy=0.
  - State IDLE; counters and sum cleared.
- Asserting rst mid-frame aborts immediately. No further writes occur, and cpu_hold returns to 1.
- Write latency: a data byte accepted at edge k drives mem_we=1 with its mem_addr and mem_wdata during cycle k..k+1. The memory captures the write at edge k+1.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- With zero-gap streaming, the last data write is captured at the same edge that accepts CSUM. No write is lost.
- load_done, load_err and the cpu_hold change take effect in the cycle after the CSUM edge. The same applies after the timeout edge.
- busy is high from the cycle after SYNC_BYTE is accepted until the cycle after CSUM is accepted or the timeout fires.

## Test plan

- Reset: hold rst high for 3 cycles. Required: cpu_hold=1, in_ready=0, mem_we=0, load_done=0, load_err=0. After release, in_ready=1.
- Basic load: send A5 10 03 11 22 33 87, one byte per cycle. Required:
  - Writes 0x10<-0x11, 0x11<-0x22, 0x12<-0x33, one cycle after each data byte.
  - Then load_done=1, cpu_hold=0, busy=0.
- Wrap and garbage: send 00 FF A5 FE 03 01 02 03 F9. Required:
  - The leading 00 and FF are discarded.
  - Writes to addresses 0xFE, 0xFF, 0x00 with data 01, 02, 03.
  - load_done=1.
- Bad checksum: send A5 10 01 AA 00. Required: write 0x10<-0xAA, then load_err=1, cpu_hold=1, load_done=0. A following valid frame clears load_err and sets load_done.
- Timeout: send A5 20 04 01 02, then stall in_valid for TIMEOUT cycles. Required: two writes occur, load_err=1 exactly TIMEOUT cycles after the last accepted byte, busy=0, cpu_hold=1.
- LEN=0 and reset mid-frame:
  - Send A5 00 00, 256 bytes of value i, then the correct CSUM. Required: 256 writes, then load_done=1.
  - Repeat the frame, asserting rst after 100 data bytes. Required: writes stop immediately, and the outputs return to their reset values.

Source files
------------

// File: rtl/prog_loader_if.sv
// Host-to-loader byte stream and loader-to-memory/CPU-control bundle.
//   in_valid/in_data/in_ready : host byte handshake
//   mem_we/mem_addr/mem_wdata : instruction memory write port
//   cpu_hold/load_done/load_err/busy : processor hold and load status
// master = host/observer side, slave = prog_loader.
interface prog_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_hold;
   logic       load_done;
   logic       load_err;
   logic       busy;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata,
      input  cpu_hold, load_done, load_err, busy
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata,
      output cpu_hold, load_done, load_err, busy
   );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses SYNC/ADDR/LEN/data/CSUM frames from a byte stream,
// writes each data byte to instruction memory and releases the CPU only when
// the frame checksum verifies.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : prog_loader_if.slave (byte handshake, memory write port, status)
module prog_loader #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic         clk,
   input  logic         rst,
   prog_loader_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam int unsigned REM_W = 9;

   typedef enum logic [2:0] {IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM} state_e;

   state_e             state_q, state_d;
   logic [7:0]         ptr_q, ptr_d;
   logic [7:0]         sum_q, sum_d;
   logic [REM_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   idle_q, idle_d;
   logic               ready_q;
   logic               we_q, we_d;
   logic [7:0]         addr_q, addr_d;
   logic [7:0]         wdata_q, wdata_d;
   logic               hold_q, hold_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;

   logic               accept_c;
   logic               timeout_c;
   logic [7:0]         csum_c;

   assign accept_c  = bus.in_valid && ready_q;
   // An accepted byte on the expiry edge wins over the timeout.
   assign timeout_c = (state_q != IDLE) && !accept_c &&
                      (idle_q == CNT_W'(TIMEOUT - 1));
   assign csum_c    = sum_q + bus.in_data;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 8'h00;
         sum_q   <= 8'h00;
         rem_q   <= '0;
         idle_q  <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sum_q   <= sum_d;
         rem_q   <= rem_d;
         idle_q  <= idle_d;
         ready_q <= 1'b1;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // Frame parser, write generation and idle timeout
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sum_d   = sum_q;
      rem_d   = rem_q;
      idle_d  = idle_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      done_d  = done_q;
      err_d   = err_q;

      if (accept_c) begin
         idle_d = '0;
      end else if (state_q != IDLE) begin
         idle_d = idle_q + CNT_W'(1);
      end

      if (accept_c) begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_data == SYNC_BYTE) begin
                  state_d = S_ADDR;
                  done_d  = 1'b0;
                  err_d   = 1'b0;
                  hold_d  = 1'b1;
               end
            end
            S_ADDR: begin
               ptr_d   = bus.in_data;
               sum_d   = bus.in_data;
               state_d = S_LEN;
            end
            S_LEN: begin
               // LEN of zero encodes a full 256-byte load
               rem_d   = (bus.in_data == 8'h00) ? REM_W'(256) : REM_W'(bus.in_data);
               sum_d   = csum_c;
               state_d = S_DATA;
            end
            S_DATA: begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = bus.in_data;
               ptr_d   = ptr_q + 8'd1;
               sum_d   = csum_c;
               rem_d   = rem_q - REM_W'(1);
               if (rem_q == REM_W'(1)) begin
                  state_d = S_CSUM;
               end
            end
            S_CSUM: begin
               if (csum_c == 8'h00) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  err_d  = 1'b1;
                  hold_d = 1'b1;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      if (timeout_c) begin
         state_d = IDLE;
         err_d   = 1'b1;
         hold_d  = 1'b1;
         idle_d  = '0;
      end

      busy_d = (state_d != IDLE);
   end

   assign bus.in_ready  = ready_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_hold  = hold_q;
   assign bus.load_done = done_q;
   assign bus.load_err  = err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames from the test plan
// plus randomized frames checked against a frame-level reference model.
module tb_prog_loader;

   localparam int unsigned TMO = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   prog_loader_if bus ();

   prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Observed memory writes as {addr, data}
   logic [15:0] wq[$];
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});
   end

   logic [7:0]  frame_q[$];
   logic [15:0] exp_w[$];
   logic        exp_ok;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model: frame_q = SYNC, ADDR, LEN, data..., CSUM
   task automatic model_frame();
      int unsigned n, s;
      logic [7:0] a;
      exp_w.delete();
      a = frame_q[1];
      n = (frame_q[2] == 8'h00) ? 256 : int'(frame_q[2]);
      s = int'(frame_q[1]) + int'(frame_q[2]);
      for (int i = 0; i < int'(n); i++) begin
         exp_w.push_back({8'((int'(a) + i) % 256), frame_q[3+i]});
         s += int'(frame_q[3+i]);
      end
      s += int'(frame_q[3+n]);
      exp_ok = ((s % 256) == 0);
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_wcount"}, wq.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
         chk({tag, "_write"}, wq[i], exp_w[i]);
   endtask

   task automatic send_frame(input string tag, input int max_gap);
      wq.delete();
      model_frame();
      foreach (frame_q[i]) begin
         send_byte(frame_q[i]);
         if (i == 0) begin
            chk({tag, "_busy_sync"}, bus.busy, 1'b1);
            chk({tag, "_hold_sync"}, bus.cpu_hold, 1'b1);
            chk({tag, "_done_clr"}, bus.load_done, 1'b0);
         end
         if (max_gap > 0) idle_cycles($urandom_range(max_gap, 0));
      end
      check_writes(tag);
      chk({tag, "_done"}, bus.load_done, exp_ok);
      chk({tag, "_err"}, bus.load_err, !exp_ok);
      chk({tag, "_hold"}, bus.cpu_hold, !exp_ok);
      chk({tag, "_busy"}, bus.busy, 1'b0);
   endtask

   task automatic set_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      frame_q.delete();
      frame_q.push_back(a);
      frame_q.push_back(b);
      frame_q.push_back(c);
   endtask

   initial begin
      int unsigned s;
      int unsigned n;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      rst = 1'b1;

      // Reset
      idle_cycles(3);
      chk("rst_hold", bus.cpu_hold, 1'b1);
      chk("rst_ready", bus.in_ready, 1'b0);
      chk("rst_we", bus.mem_we, 1'b0);
      chk("rst_done", bus.load_done, 1'b0);
      chk("rst_err", bus.load_err, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_addr", bus.mem_addr, 8'h00);
      rst = 1'b0;
      idle_cycles(1);
      chk("ready_after_rst", bus.in_ready, 1'b1);

      // Basic load
      set_frame(8'hA5, 8'h10, 8'h03);
      frame_q.push_back(8'h11); frame_q.push_back(8'h22);
      frame_q.push_back(8'h33); frame_q.push_back(8'h87);
      send_frame("basic", 0);
      chk("basic_model_ok", exp_ok, 1'b1);

      // Wrap and garbage
      send_byte(8'h00);
      send_byte(8'hFF);
      chk("garbage_busy", bus.busy, 1'b0);
      set_frame(8'hA5, 8'hFE, 8'h03);
      frame_q.push_back(8'h01); frame_q.push_back(8'h02);
      frame_q.push_back(8'h03); frame_q.push_back(8'hF9);
      send_frame("wrap", 0);

      // Bad checksum, then recovery
      set_frame(8'hA5, 8'h10, 8'h01);
      frame_q.push_back(8'hAA); frame_q.push_back(8'h00);
      send_frame("badcsum", 0);
      chk("badcsum_err", bus.load_err, 1'b1);
      set_frame(8'hA5, 8'h40, 8'h01);
      frame_q.push_back(8'h3F); frame_q.push_back(8'h80);
      send_frame("recover", 0);
      chk("recover_done", bus.load_done, 1'b1);

      // Timeout
      wq.delete();
      send_byte(8'hA5); send_byte(8'h20); send_byte(8'h04);
      send_byte(8'h01); send_byte(8'h02);
      idle_cycles(TMO - 1);
      chk("tmo_err_early", bus.load_err, 1'b0);
      chk("tmo_busy_early", bus.busy, 1'b1);
      idle_cycles(1);
      chk("tmo_err", bus.load_err, 1'b1);
      chk("tmo_busy", bus.busy, 1'b0);
      chk("tmo_hold", bus.cpu_hold, 1'b1);
      chk("tmo_done", bus.load_done, 1'b0);
      chk("tmo_wcount", wq.size(), 2);
      if (wq.size() == 2) begin
         chk("tmo_w0", wq[0], 16'h2001);
         chk("tmo_w1", wq[1], 16'h2102);
      end

      // LEN=0 full load
      set_frame(8'hA5, 8'h00, 8'h00);
      s = 0;
      for (int i = 0; i < 256; i++) begin
         frame_q.push_back(8'(i));
         s += i;
      end
      frame_q.push_back(8'((256 - (s % 256)) % 256));
      send_frame("len0", 0);
      chk("len0_ok", bus.load_done, 1'b1);

      // Randomized frames with gaps, garbage and occasional corruption
      for (int f = 0; f < 20; f++) begin
         repeat ($urandom_range(2, 0)) begin
            logic [7:0] g;
            g = 8'($urandom_range(255, 0));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g);
         end
         set_frame(8'hA5, 8'($urandom_range(255, 0)),
                   ($urandom_range(9, 0) == 0) ? 8'h00 : 8'($urandom_range(24, 1)));
         n = (frame_q[2] == 8'h00) ? 256 : int'(frame_q[2]);
         s = int'(frame_q[1]) + int'(frame_q[2]);
         for (int i = 0; i < int'(n); i++) begin
            frame_q.push_back(8'($urandom_range(255, 0)));
            s += int'(frame_q[3+i]);
         end
         frame_q.push_back(8'((256 - (s % 256)) % 256));
         if ($urandom_range(2, 0) == 0)
            frame_q[3+n] = frame_q[3+n] ^ 8'($urandom_range(255, 1));
         send_frame("rand", 3);
      end

      // Reset mid-frame after 100 data bytes
      wq.delete();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      for (int i = 0; i < 100; i++) send_byte(8'(i));
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_we", bus.mem_we, 1'b0);
      chk("midrst_hold", bus.cpu_hold, 1'b1);
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_ready", bus.in_ready, 1'b0);
      chk("midrst_done", bus.load_done, 1'b0);
      chk("midrst_err", bus.load_err, 1'b0);
      chk("midrst_addr", bus.mem_addr, 8'h00);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      idle_cycles(3);
      bus.in_valid = 1'b0;
      chk("midrst_wcount", wq.size(), 100);
      for (int i = 0; i < 100 && i < wq.size(); i++)
         chk("midrst_write", wq[i], {8'(i), 8'(i)});
      rst = 1'b0;
      idle_cycles(1);
      chk("midrst_ready_rel", bus.in_ready, 1'b1);

      // Loader recovers after reset
      set_frame(8'hA5, 8'h10, 8'h03);
      frame_q.push_back(8'h11); frame_q.push_back(8'h22);
      frame_q.push_back(8'h33); frame_q.push_back(8'h87);
      send_frame("post_rst", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
